// File: rtl/phy_tx_ctrl.sv
// Link-level TX controller: link bring-up FSM plus a small word FIFO feeding the phy_TX recirculator.
// Latency: a word accepted at edge N on an idle, up link appears on tx_data/tx_valid after edge N+1.
// Backpressure: o_ready_out drops when the FIFO is full; a word offered while not ready is dropped and flags o_overflow_err.
module phy_tx_ctrl #(
   parameter int BW          = 32,
   parameter int DEPTH       = 4,
   parameter int INIT_CYCLES = 8
) (
   input  logic                     i_clk_2f,
   input  logic                     i_reset,
   input  logic                     i_link_en,
   input  logic [BW-1:0]            i_data_in,
   input  logic                     i_valid_in,
   output logic                     o_ready_out,
   output logic [BW-1:0]            o_tx_data,
   output logic                     o_tx_valid,
   output logic                     o_active,
   output logic [1:0]               o_state,
   output logic [$clog2(DEPTH):0]   o_fifo_count,
   output logic                     o_overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(INIT_CYCLES + 1);
   localparam logic [CW-1:0] C_INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [AW:0]   C_DEPTH     = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_INIT   = 2'd1,
      S_IDLE   = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_init_cnt;
   logic [CW-1:0]   w_init_cnt_nxt;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;
   logic [BW-1:0]   r_mem [DEPTH];
   logic [BW-1:0]   r_tx_data;
   logic            r_tx_valid;
   logic            r_overflow;

   logic            w_link_up;
   logic            w_ready;
   logic            w_push;
   logic            w_pop;
   logic            w_reject;

   // Ready depends only on registered state so a same-cycle pop never frees a slot for a push.
   assign w_link_up = (r_state == S_IDLE) || (r_state == S_ACTIVE);
   assign w_ready   = !i_reset && (r_state != S_RESET) && (r_count < C_DEPTH);
   assign w_push    = i_valid_in && w_ready;
   assign w_pop     = !i_reset && w_link_up && i_link_en && (r_count != '0);
   assign w_reject  = !i_reset && i_valid_in && !w_ready && (r_state != S_RESET);

   assign o_ready_out    = w_ready;
   assign o_active       = !i_reset && w_link_up;
   assign o_state        = r_state;
   assign o_fifo_count   = r_count;
   assign o_tx_data      = r_tx_data;
   assign o_tx_valid     = r_tx_valid;
   assign o_overflow_err = r_overflow;

   // Next-state and INIT counter: link_en must stay high INIT_CYCLES cycles in a row to bring the link up.
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = '0;
      case (r_state)
         S_RESET: begin
            w_state_nxt = S_INIT;
         end
         S_INIT: begin
            if (!i_link_en) begin
               w_state_nxt = S_INIT;
            end else if (r_init_cnt == C_INIT_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_init_cnt_nxt = r_init_cnt + CW'(1);
            end
         end
         default: begin
            if (!i_link_en) begin
               w_state_nxt = S_INIT;
            end else if (w_pop) begin
               w_state_nxt = S_ACTIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // State register and INIT counter.
   always_ff @(posedge i_clk_2f) begin
      if (i_reset) begin
         r_state    <= S_RESET;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
      end
   end

   // FIFO storage; contents need no reset because the pointers and count define validity.
   always_ff @(posedge i_clk_2f) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data_in;
      end
   end

   // FIFO pointers/count, output word register and sticky overflow flag.
   always_ff @(posedge i_clk_2f) begin
      if (i_reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr    <= r_rptr + AW'(1);
            r_tx_data <= r_mem[r_rptr];
         end
         r_tx_valid <= w_pop;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_reject) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Directed bench for phy_tx_ctrl: table-driven bring-up and single-word transfer, then hand-written multi-cycle sequences.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Every wait on the DUT is bounded by a fixed cycle budget.
module tb_phy_tx_ctrl;

   logic        clk_2f;
   logic        reset;
   logic        link_en;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        active;
   logic [1:0]  state;
   logic [2:0]  fifo_count;
   logic        overflow_err;

   int n_pass;
   int n_tot;

   phy_tx_ctrl #(.BW(32), .DEPTH(4), .INIT_CYCLES(8)) dut (
      .i_clk_2f       (clk_2f),
      .i_reset        (reset),
      .i_link_en      (link_en),
      .i_data_in      (data_in),
      .i_valid_in     (valid_in),
      .o_ready_out    (ready_out),
      .o_tx_data      (tx_data),
      .o_tx_valid     (tx_valid),
      .o_active       (active),
      .o_state        (state),
      .o_fifo_count   (fifo_count),
      .o_overflow_err (overflow_err)
   );

   initial clk_2f = 1'b0;
   always #5 clk_2f = ~clk_2f;

   typedef struct {
      bit          rst;
      bit          en;
      bit          vld;
      logic [31:0] dat;
      logic [1:0]  st;
      logic [2:0]  cnt;
      bit          txv;
      logic [31:0] txd;
      bit          rdy;
      bit          act;
   } vec_t;

   vec_t vec [14];

   task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_tot++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act_v, exp_v);
   endtask

   task automatic tick();
      @(posedge clk_2f);
      #1;
   endtask

   // Buffer words in INIT with link_en low; leaves valid_in low afterwards.
   task automatic fill_in_init(input logic [31:0] base, input int n);
      link_en = 1'b0;
      tick();
      for (int k = 0; k < n; k++) begin
         valid_in = 1'b1;
         data_in  = base + 32'(k);
         tick();
      end
      valid_in = 1'b0;
   endtask

   initial begin
      int got;
      int maxc;
      int first_edge;
      bit gap;
      n_pass   = 0;
      n_tot    = 0;
      reset    = 1'b1;
      link_en  = 1'b1;
      valid_in = 1'b0;
      data_in  = 32'h0;

      // rst en vld dat | state cnt txv txd rdy act
      vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'd0, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0};
      vec[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'd0, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0};
      vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd1, 3'd0, 1'b0, 32'h0,         1'b1, 1'b0};
      for (int i = 3; i < 10; i++) vec[i] = vec[2];
      vec[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2, 3'd0, 1'b0, 32'h0,         1'b1, 1'b1};
      vec[11] = '{1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 2'd2, 3'd1, 1'b0, 32'h0,         1'b1, 1'b1};
      vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd3, 3'd0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
      vec[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2, 3'd0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1};

      // Bring-up and single word.
      for (int i = 0; i < 14; i++) begin
         reset    = vec[i].rst;
         link_en  = vec[i].en;
         valid_in = vec[i].vld;
         data_in  = vec[i].dat;
         tick();
         chk($sformatf("v%0d_state", i),  32'(state),        32'(vec[i].st));
         chk($sformatf("v%0d_count", i),  32'(fifo_count),   32'(vec[i].cnt));
         chk($sformatf("v%0d_txv", i),    32'(tx_valid),     32'(vec[i].txv));
         chk($sformatf("v%0d_txd", i),    tx_data,           vec[i].txd);
         chk($sformatf("v%0d_ready", i),  32'(ready_out),    32'(vec[i].rdy));
         chk($sformatf("v%0d_active", i), 32'(active),       32'(vec[i].act));
         chk($sformatf("v%0d_ovf", i),    32'(overflow_err), 32'(0));
      end

      // Streaming: 16 back-to-back words from IDLE.
      got  = 0;
      maxc = 0;
      gap  = 1'b0;
      for (int c = 0; c < 24; c++) begin
         valid_in = (c < 16);
         data_in  = 32'(c);
         tick();
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
         if (tx_valid) begin
            chk("stream_data", tx_data, 32'(got));
            got++;
         end else if (got > 0 && got < 16) begin
            gap = 1'b1;
         end
      end
      valid_in = 1'b0;
      chk("stream_words", 32'(got), 32'd16);
      chk("stream_gap", 32'(gap), 32'd0);
      chk("stream_maxcount", 32'(maxc), 32'd1);
      chk("stream_ovf", 32'(overflow_err), 32'd0);

      // Fill and overflow in INIT, then drain after re-init.
      fill_in_init(32'hC0DE_0000, 4);
      chk("fill_state", 32'(state), 32'd1);
      chk("fill_count", 32'(fifo_count), 32'd4);
      valid_in = 1'b1;
      data_in  = 32'hDEAD_BEEF;
      #1;
      chk("fill_ready_full", 32'(ready_out), 32'd0);
      tick();
      valid_in = 1'b0;
      chk("fill_count_after_reject", 32'(fifo_count), 32'd4);
      chk("fill_ovf_set", 32'(overflow_err), 32'd1);
      link_en    = 1'b1;
      got        = 0;
      first_edge = -1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (tx_valid) begin
            if (first_edge < 0) first_edge = e;
            chk("drain_data", tx_data, 32'hC0DE_0000 + 32'(got));
            got++;
         end
      end
      chk("drain_first_edge", 32'(first_edge), 32'd9);
      chk("drain_words", 32'(got), 32'd4);
      chk("drain_ovf_sticky", 32'(overflow_err), 32'd1);

      // Link drop after two of four words.
      fill_in_init(32'hB000_0000, 4);
      link_en = 1'b1;
      got     = 0;
      for (int e = 1; e <= 20 && got < 2; e++) begin
         tick();
         if (tx_valid) begin
            chk("drop_pre_data", tx_data, 32'hB000_0000 + 32'(got));
            got++;
         end
      end
      chk("drop_pre_words", 32'(got), 32'd2);
      link_en = 1'b0;
      tick();
      chk("drop_state", 32'(state), 32'd1);
      chk("drop_txv", 32'(tx_valid), 32'd0);
      chk("drop_active", 32'(active), 32'd0);
      chk("drop_count", 32'(fifo_count), 32'd2);
      link_en = 1'b1;
      got     = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (tx_valid) begin
            chk("drop_post_data", tx_data, 32'hB000_0002 + 32'(got));
            got++;
         end
      end
      chk("drop_post_words", 32'(got), 32'd2);

      // Full FIFO with same-cycle pop, then reset mid-transfer.
      fill_in_init(32'hD000_0000, 4);
      link_en = 1'b1;
      for (int e = 0; e < 8; e++) tick();
      chk("full_idle_state", 32'(state), 32'd2);
      chk("full_idle_count", 32'(fifo_count), 32'd4);
      valid_in = 1'b1;
      data_in  = 32'h1234_5678;
      #1;
      chk("full_pop_ready", 32'(ready_out), 32'd0);
      tick();
      valid_in = 1'b0;
      chk("full_pop_count", 32'(fifo_count), 32'd3);
      chk("full_pop_txv", 32'(tx_valid), 32'd1);
      chk("full_pop_txd", tx_data, 32'hD000_0000);
      chk("full_pop_ready_back", 32'(ready_out), 32'd1);
      reset = 1'b1;
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_txv", 32'(tx_valid), 32'd0);
      chk("rst_txd", tx_data, 32'h0);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_release_state", 32'(state), 32'd1);
      chk("rst_release_count", 32'(fifo_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/phy_tx_ctrl.md
# phy_tx_ctrl

Link-level controller that sits in front of the `phy_TX` datapath on the `clk_2f` domain. It sequences link bring-up through RESET, INIT, IDLE and ACTIVE states, and drives the datapath's `active` qualifier. It also buffers upstream 32-bit words in a small FIFO with a valid/ready handshake, and issues them to the recirculator as a `tx_data`/`tx_valid` stream at up to one word per cycle. Overflow attempts are flagged with a sticky error bit.

## Interface
Parameters:
- `BW`, 32, data word width.
- `DEPTH`, 4, FIFO depth in words (power of two, ≥2).
- `INIT_CYCLES`, 8, consecutive `link_en` cycles required in INIT before the link is declared up (≥1).

Ports:
- `clk_2f`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `link_en`  in  1  link enable from management; low forces or holds INIT.
- `data_in`  in  BW  upstream word.
- `valid_in`  in  1  upstream word valid.
- `ready_out`  out  1  FIFO can accept a word this cycle.
- `tx_data`  out  BW  word to recirculator `data_input`.
- `tx_valid`  out  1  `tx_data` valid, to recirculator `valid`.
- `active`  out  1  link up, to recirculator `active`.
- `state`  out  2  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- `fifo_count`  out  $clog2(DEPTH)+1  words currently buffered.
- `overflow_err`  out  1  sticky; set on a rejected write.

## Operation
- The design has one clock (`clk_2f`). `reset` is synchronous and active-high.
- While `reset` is high, on each edge:
  - `state`=RESET.
  - FIFO pointers, `fifo_count` and the INIT counter go to 0.
  - `tx_data`=0, `tx_valid`=0, `overflow_err`=0.
- Combinational outputs during reset: `ready_out`=0, `active`=0.
- FSM transitions (next state at each edge, reset low):
  - RESET → INIT unconditionally.
  - INIT:
    - If `link_en`=0, the counter clears to 0 and the state stays INIT.
    - Otherwise the counter increments.
    - When `link_en`=1 and the counter = INIT_CYCLES−1, go to IDLE and clear the counter.
  - IDLE/ACTIVE:
    - If `link_en`=0, go to INIT. The counter is 0 and the FIFO contents are retained.
    - Otherwise, if a pop occurs this cycle, go to ACTIVE; else go to IDLE.
- `active` = 1 iff `state` ∈ {IDLE, ACTIVE}, decoded combinationally from the state register.
- Push:
  - `ready_out` = (`state`≠RESET) && (`fifo_count`<DEPTH). It depends only on registered state, not on a same-cycle pop.
  - A push occurs when `valid_in` && `ready_out`: `data_in` is written at the write pointer.
  - Pushes are allowed in INIT, IDLE and ACTIVE.
- Pop:
  - A pop occurs when `state` ∈ {IDLE, ACTIVE} && `link_en` && `fifo_count`>0.
  - On a pop, `tx_data` takes the head word and `tx_valid`=1 at the next edge. Otherwise `tx_valid`=0 and `tx_data` holds its last value.
- `state`==ACTIVE iff `tx_valid`==1.
- Pointers wrap modulo DEPTH. `fifo_count` changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- Overflow: `valid_in`=1 with `ready_out`=0 while `state`≠RESET sets `overflow_err`. The word is dropped. The flag clears only on `reset`.

## Timing
- Word accepted at edge N with the FIFO otherwise empty and the link up: popped at edge N+1, so `tx_valid`=1 and `tx_data` = word during cycle N+1.
- Throughput is 1 word/cycle sustained with simultaneous push and pop.
- Link bring-up: `reset` released before edge 0 gives INIT after edge 0. With `link_en` held high, IDLE follows after edge INIT_CYCLES.
- Dropping `link_en` in ACTIVE:
  - The next edge gives INIT with `tx_valid`=0 and `active`=0.
  - No word is lost; the FIFO keeps its count.
- Full FIFO with a pop in the same cycle: `ready_out` is still 0 that cycle and the push is rejected (overflow if `valid_in`=1). `ready_out` returns to 1 the following cycle.
- Reset asserted mid-transfer: at the next edge everything is at its reset value and buffered words are discarded.

## Test plan
- Bring-up: reset 2 cycles, `link_en`=1 → `state` 0→1, INIT for 8 cycles, then 2 with `active`=1; `ready_out`=1 from the first INIT cycle.
- Single word: in IDLE push 0xA5A5_0001 at edge N → `tx_valid`=1, `tx_data`=0xA5A5_0001, `state`=3 during cycle N+1 only; then back to IDLE, `fifo_count`=0.
- Streaming: push 16 words 0x0..0xF back-to-back in IDLE → 16 consecutive `tx_valid` cycles in order; `fifo_count` never exceeds 1; `overflow_err`=0.
- Fill and overflow: hold `link_en`=0 in INIT and push 5 words → first 4 accepted, `fifo_count`=4, 5th rejected with `ready_out`=0, `overflow_err`=1. Raise `link_en` → after 8 cycles the 4 words drain in order and `overflow_err` stays 1.
- Link drop mid-stream: drop `link_en` after 2 of 4 buffered words are sent → INIT next edge, `tx_valid`=0, `fifo_count`=2. Re-enable → remaining 2 words sent after re-init.
- Reset mid-operation: assert `reset` with `fifo_count`=3 and `tx_valid`=1 → next edge all outputs at reset values, `fifo_count`=0, `state`=0.
